// File: rtl/scan_chain_ctrl_if.sv
// Host handshake plus scan-chain pins of scan_chain_ctrl, bundled so the
// controller sees one port. The master side is the host and the chip under scan.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 64
);
  logic                 start;
  logic [CHAIN_LEN-1:0] data_in;
  logic [CHAIN_LEN-1:0] data_out;
  logic                 busy;
  logic                 done;
  logic                 sc_sout;
  logic                 sc_sin;
  logic                 sc_clk;
  logic                 sc_load;

  modport master (
    output start, data_in, sc_sout,
    input  data_out, busy, done, sc_sin, sc_clk, sc_load
  );

  modport slave (
    input  start, data_in, sc_sout,
    output data_out, busy, done, sc_sin, sc_clk, sc_load
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan-chain master: shifts a parallel word out on sc_sin under a divided,
// registered scan clock while capturing sc_sout, then strobes sc_load.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN     = 64,
  parameter int DIV_HALF      = 1000000,
  parameter bit LSB_FIRST     = 1'b1,
  parameter bit IDLE_CLK_HIGH = 1'b1
) (
  input logic              clki,
  input logic              rst,
  scan_chain_ctrl_if.slave bus
);
  localparam int DIV_W = $clog2(DIV_HALF + 1);
  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     divCnt_q, divCnt_d;
  logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
  logic [CHAIN_LEN-1:0] shiftReg_q, shiftReg_d;
  logic [CHAIN_LEN-1:0] capReg_q, capReg_d;
  logic [CHAIN_LEN-1:0] dataOut_q, dataOut_d;
  logic                 scClk_q, scClk_d;
  logic                 loadHalf_q, loadHalf_d;

  logic                 divLast;
  logic [CHAIN_LEN:0]   capExt, shiftExt;
  logic [CHAIN_LEN-1:0] capNext, shiftNext;

  // One spare bit lets the shift slices stay legal when CHAIN_LEN is 1.
  always_comb begin
    if (LSB_FIRST) begin
      capExt    = {capReg_q, bus.sc_sout};
      capNext   = capExt[CHAIN_LEN-1:0];
      shiftExt  = {1'b0, shiftReg_q};
      shiftNext = shiftExt[CHAIN_LEN:1];
    end else begin
      capExt    = {bus.sc_sout, capReg_q};
      capNext   = capExt[CHAIN_LEN:1];
      shiftExt  = {shiftReg_q, 1'b0};
      shiftNext = shiftExt[CHAIN_LEN-1:0];
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q    <= IDLE;
      divCnt_q   <= '0;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      capReg_q   <= '0;
      dataOut_q  <= '0;
      scClk_q    <= IDLE_CLK_HIGH;
      loadHalf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
      capReg_q   <= capReg_d;
      dataOut_q  <= dataOut_d;
      scClk_q    <= scClk_d;
      loadHalf_q <= loadHalf_d;
    end
  end

  assign divLast = (divCnt_q == DIV_LAST);

  // sc_clk is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    divCnt_d   = divCnt_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    capReg_d   = capReg_q;
    dataOut_d  = dataOut_q;
    scClk_d    = scClk_q;
    loadHalf_d = loadHalf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shiftReg_d = bus.data_in;
          divCnt_d   = '0;
          bitCnt_d   = '0;
          loadHalf_d = 1'b0;
          scClk_d    = 1'b0;
          state_d    = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (divLast) begin
          divCnt_d = '0;
          scClk_d  = 1'b1;
          capReg_d = capNext;
          state_d  = SHIFT_HI;
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (divLast) begin
          divCnt_d   = '0;
          shiftReg_d = shiftNext;
          bitCnt_d   = bitCnt_q + 1'b1;
          scClk_d    = 1'b0;
          state_d    = (bitCnt_q == BIT_LAST) ? LOAD : SHIFT_LO;
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      LOAD: begin
        // Two passes of the divider give the double-length load strobe.
        if (divLast) begin
          divCnt_d   = '0;
          loadHalf_d = 1'b1;
          if (loadHalf_q) begin
            loadHalf_d = 1'b0;
            dataOut_d  = capReg_q;
            scClk_d    = IDLE_CLK_HIGH;
            state_d    = DONE;
          end
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    bus.sc_load  = (state_q == LOAD);
    bus.sc_clk   = scClk_q;
    bus.sc_sin   = LSB_FIRST ? shiftReg_q[0] : shiftReg_q[CHAIN_LEN-1];
    bus.data_out = dataOut_q;
  end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: three controllers (LSB-first, MSB-first, 1-bit fast) checked
// cycle by cycle against hand-computed scan timing and captured words.
module tb_scan_chain_ctrl;
  logic clki;
  logic rst;
  logic extMode;
  logic extPreload;
  logic extPrevClk;
  logic [7:0] extReg;

  int compareCount = 0;
  int failCount    = 0;

  scan_chain_ctrl_if #(.CHAIN_LEN(8)) ifA ();
  scan_chain_ctrl_if #(.CHAIN_LEN(8)) ifB ();
  scan_chain_ctrl_if #(.CHAIN_LEN(1)) ifC ();

  scan_chain_ctrl #(.CHAIN_LEN(8), .DIV_HALF(2), .LSB_FIRST(1'b1), .IDLE_CLK_HIGH(1'b1))
    dutA (.clki(clki), .rst(rst), .bus(ifA));
  scan_chain_ctrl #(.CHAIN_LEN(8), .DIV_HALF(2), .LSB_FIRST(1'b0), .IDLE_CLK_HIGH(1'b1))
    dutB (.clki(clki), .rst(rst), .bus(ifB));
  scan_chain_ctrl #(.CHAIN_LEN(1), .DIV_HALF(1), .LSB_FIRST(1'b1), .IDLE_CLK_HIGH(1'b1))
    dutC (.clki(clki), .rst(rst), .bus(ifC));

  assign ifA.sc_sout = extMode ? extReg[7] : ifA.sc_sin;
  assign ifB.sc_sout = ifB.sc_sin;
  assign ifC.sc_sout = ifC.sc_sin;

  initial clki = 1'b0;
  always #5 clki = ~clki;

  // Chip-side chain for dutA: MSB out first, shifts in sc_sin on each sc_clk rise.
  always @(posedge clki) begin
    if (extPreload)
      extReg <= 8'h5A;
    else if (ifA.sc_clk && !extPrevClk)
      extReg <= {extReg[6:0], ifA.sc_sin};
    extPrevClk <= ifA.sc_clk;
  end

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] dA, input logic [7:0] dB, input logic dC,
                               input logic sA, input logic sB, input logic sC);
    ifA.data_in = dA;
    ifB.data_in = dB;
    ifC.data_in = dC;
    ifA.start   = sA;
    ifB.start   = sB;
    ifC.start   = sC;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int k;
    int rises;
    logic prevClk;
    logic expClk;
    logic [7:0] seqA;
    logic [7:0] seqB;

    // Bit k of seqX is the k-th bit expected on sc_sin for data_in 8'hB1.
    seqA = 8'b1011_0001;
    seqB = 8'b1000_1101;

    rst        = 1'b1;
    extMode    = 1'b0;
    extPreload = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_A_sc_clk", 64'(ifA.sc_clk), 64'(1));
    checkOutput("rst_A_sc_sin", 64'(ifA.sc_sin), 64'(0));
    checkOutput("rst_A_sc_load", 64'(ifA.sc_load), 64'(0));
    checkOutput("rst_A_data_out", 64'(ifA.data_out), 64'(0));
    checkOutput("rst_A_busy", 64'(ifA.busy), 64'(0));
    checkOutput("rst_A_done", 64'(ifA.done), 64'(0));
    checkOutput("rst_C_sc_clk", 64'(ifC.sc_clk), 64'(1));

    rst = 1'b0;
    tick();

    $display("[TB] loopback scans on all three instances");
    applyStimulus(8'hB1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b1);
    prevClk = ifA.sc_clk;
    rises   = 0;
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 38; n++) begin
      k = (n - 1) / 4;
      if (n <= 32) begin
        checkOutput($sformatf("A_sin_t%0d", n), 64'(ifA.sc_sin), 64'(seqA[k]));
        checkOutput($sformatf("B_sin_t%0d", n), 64'(ifB.sc_sin), 64'(seqB[k]));
        expClk = (((n - 1) % 4) >= 2);
      end else begin
        expClk = (n >= 37);
      end
      checkOutput($sformatf("A_sc_clk_t%0d", n), 64'(ifA.sc_clk), 64'(expClk));
      checkOutput($sformatf("A_sc_load_t%0d", n), 64'(ifA.sc_load), 64'(n >= 33 && n <= 36));
      checkOutput($sformatf("A_done_t%0d", n), 64'(ifA.done), 64'(n == 37));
      checkOutput($sformatf("B_done_t%0d", n), 64'(ifB.done), 64'(n == 37));
      checkOutput($sformatf("A_busy_t%0d", n), 64'(ifA.busy), 64'(n <= 37));
      checkOutput($sformatf("A_data_out_t%0d", n), 64'(ifA.data_out), (n >= 37) ? 64'h8D : 64'h0);
      checkOutput($sformatf("B_data_out_t%0d", n), 64'(ifB.data_out), (n >= 37) ? 64'h8D : 64'h0);
      if (n <= 36 && ifA.sc_clk && !prevClk)
        rises++;
      prevClk = ifA.sc_clk;
      if (n <= 6) begin
        checkOutput($sformatf("C_sc_clk_t%0d", n), 64'(ifC.sc_clk), 64'(n == 2 || n >= 5));
        checkOutput($sformatf("C_sc_load_t%0d", n), 64'(ifC.sc_load), 64'(n == 3 || n == 4));
        checkOutput($sformatf("C_done_t%0d", n), 64'(ifC.done), 64'(n == 5));
        checkOutput($sformatf("C_busy_t%0d", n), 64'(ifC.busy), 64'(n <= 5));
        checkOutput($sformatf("C_data_out_t%0d", n), 64'(ifC.data_out), 64'(n >= 5));
        if (n <= 2)
          checkOutput($sformatf("C_sin_t%0d", n), 64'(ifC.sc_sin), 64'(1));
      end
      if (n < 38)
        tick();
    end
    checkOutput("A_sc_clk_rises", 64'(rises), 64'(8));

    $display("[TB] external chain preloaded with 5A");
    extMode    = 1'b1;
    extPreload = 1'b1;
    tick();
    extPreload = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 37; n++) begin
      checkOutput($sformatf("ext_done_t%0d", n), 64'(ifA.done), 64'(n == 37));
      if (n == 20)
        checkOutput("ext_data_out_held", 64'(ifA.data_out), 64'h8D);
      if (n < 37)
        tick();
    end
    checkOutput("ext_data_out", 64'(ifA.data_out), 64'h5A);
    checkOutput("ext_chain_final", 64'(extReg), 64'h00);
    extMode = 1'b0;
    tick();

    $display("[TB] reset mid-scan");
    applyStimulus(8'hB1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'hB1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 15; n++) begin
      checkOutput($sformatf("abort_done_t%0d", n), 64'(ifA.done), 64'(0));
      checkOutput($sformatf("abort_busy_t%0d", n), 64'(ifA.busy), 64'(1));
      if (n == 15)
        checkOutput("abort_data_out_held", 64'(ifA.data_out), 64'h5A);
      if (n < 15)
        tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_sc_clk", 64'(ifA.sc_clk), 64'(1));
    checkOutput("abort_busy", 64'(ifA.busy), 64'(0));
    checkOutput("abort_sc_load", 64'(ifA.sc_load), 64'(0));
    checkOutput("abort_data_out", 64'(ifA.data_out), 64'h0);
    checkOutput("abort_done", 64'(ifA.done), 64'(0));
    tick();
    applyStimulus(8'hB1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 37; n++) begin
      checkOutput($sformatf("restart_done_t%0d", n), 64'(ifA.done), 64'(n == 37));
      if (n == 36)
        checkOutput("restart_data_out_cleared", 64'(ifA.data_out), 64'h0);
      if (n < 37)
        tick();
    end
    checkOutput("restart_data_out", 64'(ifA.data_out), 64'h8D);
    tick();

    $display("[TB] start held high across two scans");
    applyStimulus(8'hB1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int n = 1; n <= 76; n++) begin
      checkOutput($sformatf("held_done_t%0d", n), 64'(ifA.done), 64'(n == 37 || n == 75));
      checkOutput($sformatf("held_busy_t%0d", n), 64'(ifA.busy), 64'(n != 38 && n != 76));
      if (n == 75)
        checkOutput("held_data_out", 64'(ifA.data_out), 64'h8D);
      if (n < 76)
        tick();
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
